// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: start/complete/timeout sequencing for the multicycle mul/div unit,
// with shared-writeport arbitration and structural/RAW pipeline holds.
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int EXC_MUL    = 4,
    parameter int EXC_DIV    = 5,
    parameter int STATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [4:0]  x_rd,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_reads_rs,
    input  logic        d_reads_rt,
    input  logic        unit_ready,
    input  logic        unit_exception,
    input  logic        mw_we,
    output logic        unit_ctrl_mult,
    output logic        unit_ctrl_div,
    output logic        busy,
    output logic        hold_fd,
    output logic        hold_x,
    output logic        pw_we,
    output logic [4:0]  pw_rd,
    output logic        pw_sel_status,
    output logic [31:0] pw_status
);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, WB_PEND} state_e;

    state_e        state_q, state_d;
    logic          op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic          exc_q, exc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       start_any, accept, raw;
    logic [4:0] pend_rd;

    assign start_any = start_mult | start_div;
    // Start pulses are suppressed while reset is held so every output is quiet in reset.
    assign accept    = (state_q == IDLE) & start_any & ~reset;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        exc_d   = exc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_any) begin
                state_d = RUN;
                op_d    = ~start_mult;
                rd_d    = x_rd;
                cnt_d   = '0;
                exc_d   = 1'b0;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (unit_ready) begin
                    exc_d   = unit_exception;
                    state_d = WB_PEND;
                end else if (cnt_q == CW'(MAX_CYCLES - 1)) begin
                    exc_d   = 1'b1;
                    state_d = WB_PEND;
                end
            end
            WB_PEND: if (!mw_we) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            rd_q    <= '0;
            exc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign unit_ctrl_mult = accept & start_mult;
    assign unit_ctrl_div  = accept & ~start_mult;
    assign busy           = state_q != IDLE;

    assign pw_we         = (state_q == WB_PEND) & ~mw_we;
    assign pw_sel_status = pw_we & exc_q;
    assign pw_rd         = pw_we ? (exc_q ? 5'(STATUS_REG) : rd_q) : 5'd0;
    assign pw_status     = pw_sel_status ? (op_q ? 32'(EXC_DIV) : 32'(EXC_MUL)) : 32'd0;

    assign pend_rd = busy ? rd_q : x_rd;
    assign raw     = (pend_rd != 5'd0) &
                     ((d_reads_rs & (d_rs == pend_rd)) | (d_reads_rt & (d_rt == pend_rd)));
    assign hold_x  = busy & start_any;
    assign hold_fd = ((accept | busy) & raw) | hold_x;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed + randomized checks of multdiv_sequencer against a
// transaction-level timing model (accept cycle, ready/timeout cycle, MW stall count).
module tb_multdiv_sequencer;
    localparam int MAXC = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0, start_div = 1'b0;
    logic [4:0]  x_rd = '0, d_rs = '0, d_rt = '0;
    logic        d_reads_rs = 1'b0, d_reads_rt = 1'b0;
    logic        unit_ready = 1'b0, unit_exception = 1'b0, mw_we = 1'b0;
    logic        unit_ctrl_mult, unit_ctrl_div, busy, hold_fd, hold_x, pw_we, pw_sel_status;
    logic [4:0]  pw_rd;
    logic [31:0] pw_status;

    int total = 0;
    int bad   = 0;

    multdiv_sequencer dut (
        .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .x_rd(x_rd), .d_rs(d_rs), .d_rt(d_rt), .d_reads_rs(d_reads_rs), .d_reads_rt(d_reads_rt),
        .unit_ready(unit_ready), .unit_exception(unit_exception), .mw_we(mw_we),
        .unit_ctrl_mult(unit_ctrl_mult), .unit_ctrl_div(unit_ctrl_div), .busy(busy),
        .hold_fd(hold_fd), .hold_x(hold_x), .pw_we(pw_we), .pw_rd(pw_rd),
        .pw_sel_status(pw_sel_status), .pw_status(pw_status)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [4:0] pick(input logic [4:0] rd);
        int s = $urandom % 3;
        return s == 0 ? rd : (s == 1 ? 5'd0 : 5'($urandom));
    endfunction

    task automatic chk_all(input int k, input bit c_mul, input bit c_div, input bit e_busy,
                           input bit e_we, input logic [4:0] e_rd, input bit e_sel,
                           input logic [31:0] e_st, input bit e_hfd, input bit e_hx);
        chk("ctrl_mult", k, 32'(unit_ctrl_mult), 32'(c_mul));
        chk("ctrl_div", k, 32'(unit_ctrl_div), 32'(c_div));
        chk("busy", k, 32'(busy), 32'(e_busy));
        chk("pw_we", k, 32'(pw_we), 32'(e_we));
        chk("pw_rd", k, 32'(pw_rd), 32'(e_rd));
        chk("pw_sel", k, 32'(pw_sel_status), 32'(e_sel));
        chk("pw_status", k, pw_status, e_st);
        chk("hold_fd", k, 32'(hold_fd), 32'(e_hfd));
        chk("hold_x", k, 32'(hold_x), 32'(e_hx));
        chk("we_overlap", k, 32'(pw_we & mw_we), 32'd0);
    endtask

    // r = RUN cycle carrying unit_ready (>MAXC means never), m = MW stall cycles in WB_PEND.
    // chain: a further mul/div (div if chain_div) waits in X throughout this operation.
    task automatic run_op(input bit div, input bit both, input logic [4:0] rd, input int r,
                          input bit uexc, input int m, input bit chain, input bit chain_div);
        int  c    = (r <= MAXC ? r : MAXC) + 1;
        bit  exc  = (r <= MAXC) ? uexc : 1'b1;
        bit  is_d = div & ~both;
        bit  raw, we;
        for (int k = 0; k <= c + m; k++) begin
            @(negedge clock);
            start_mult = (k == 0) ? (!div || both) : (chain && !chain_div);
            start_div  = (k == 0) ? (div || both) : (chain && chain_div);
            x_rd       = (k == 0) ? rd : 5'($urandom);
            unit_ready = (k >= c) ? 1'($urandom) : (k == r);
            unit_exception = (k == r) ? uexc : 1'($urandom);
            mw_we      = (k >= c && k < c + m) ? 1'b1 : ((k < c) ? 1'($urandom) : 1'b0);
            d_rs = pick(rd); d_rt = pick(rd);
            d_reads_rs = 1'($urandom); d_reads_rt = 1'($urandom);
            #1;
            raw = (rd != 0) && ((d_reads_rs && d_rs == rd) || (d_reads_rt && d_rt == rd));
            we  = (k == c + m);
            chk_all(k, k == 0 && !is_d, k == 0 && is_d, k >= 1, we,
                    we ? (exc ? 5'd30 : rd) : 5'd0, we && exc,
                    (we && exc) ? (is_d ? 32'd5 : 32'd4) : 32'd0,
                    raw || (k >= 1 && chain), k >= 1 && chain);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        start_mult = 0; start_div = 0;
        x_rd = 5'($urandom); d_rs = 5'($urandom); d_rt = 5'($urandom);
        d_reads_rs = 1'($urandom); d_reads_rt = 1'($urandom);
        unit_ready = 1'($urandom); unit_exception = 1'($urandom); mw_we = 1'($urandom);
        #1;
        chk_all(-1, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0, 0);
    endtask

    initial begin
        #2;
        start_mult = 1; start_div = 1; x_rd = 5'd3;
        #1;
        chk_all(-2, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0, 0);
        start_mult = 0; start_div = 0;
        @(negedge clock);
        reset = 0;
        idle_cycle();
        run_op(0, 0, 5'd5, 17, 0, 0, 0, 0);
        idle_cycle();
        run_op(1, 0, 5'd7, 9, 1, 0, 0, 0);
        run_op(0, 0, 5'd7, 9, 1, 0, 0, 0);
        idle_cycle();
        run_op(1, 0, 5'd12, 99, 0, 0, 0, 0);
        run_op(0, 0, 5'd12, 99, 0, 1, 0, 0);
        run_op(1, 0, 5'd13, MAXC, 0, 0, 0, 0);
        run_op(0, 0, 5'd14, MAXC - 1, 0, 0, 0, 0);
        run_op(0, 0, 5'd6, 4, 0, 3, 0, 0);
        idle_cycle();
        run_op(0, 0, 5'd9, 8, 0, 1, 1, 1);
        run_op(1, 0, 5'd9, 3, 0, 0, 0, 0);
        idle_cycle();
        run_op(1, 0, 5'd0, 2, 0, 0, 0, 0);
        run_op(0, 1, 5'd11, 1, 1, 0, 0, 0);
        idle_cycle();
        for (int i = 0; i < 10; i++) begin
            run_op(1'($urandom), 1'($urandom_range(0, 7) == 0), 5'($urandom),
                   $urandom_range(1, 44), 1'($urandom), $urandom_range(0, 3), 0, 0);
            if ($urandom % 2) idle_cycle();
        end
        // Reset during RUN abandons the operation.
        @(negedge clock);
        start_mult = 1; x_rd = 5'd9; unit_ready = 0; mw_we = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            start_mult = 0; d_reads_rs = 1; d_rs = 5'd9;
        end
        #1;
        chk("busy_mid", 10, 32'(busy), 32'd1);
        chk("hfd_mid", 10, 32'(hold_fd), 32'd1);
        reset = 1;
        #1;
        chk_all(-3, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0, 0);
        @(negedge clock);
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            unit_ready = (k == 0); mw_we = 0;
            #1;
            chk_all(-4, 0, 0, 0, 0, 5'd0, 0, 32'd0, 0, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
